// File: rtl/uart_dbg_rx.sv
// uart_dbg_rx: debug UART receiver feeding a first-word-fall-through byte queue drained with rd.
// Frames are 8N1 by default; defining UART_DBG_RX_PARITY_EN switches to 8E1 with a PARITY state.
module uart_dbg_rx #(
    parameter int SYS_CLK_FREQ   = 12000000,
    parameter int BAUD_RATE      = 115200,
    parameter int MSG_QUEUE_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] msg,
    output logic       empty,
    output logic       overflow,
    output logic       frame_err
);
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(MSG_QUEUE_SIZE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(MSG_QUEUE_SIZE);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_dbg_rx: SYS_CLK_FREQ / BAUD_RATE must be at least 4");
    end
    if (MSG_QUEUE_SIZE < 2 || (MSG_QUEUE_SIZE & (MSG_QUEUE_SIZE - 1)) != 0) begin : g_bad_depth
        $error("uart_dbg_rx: MSG_QUEUE_SIZE must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
`ifdef UART_DBG_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          push;
`ifdef UART_DBG_RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    // Sync flops reset to idle-high so reset never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_DBG_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_DBG_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CW'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_DBG_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            // The sync flops read high for two clocks after reset, so a single high
            // sample proves nothing; demand a full bit time of idle line instead.
            WAIT_IDLE: begin
                clk_cnt_d = rx_s_q ? clk_cnt_q + CW'(1) : '0;
                if (rx_s_q && clk_cnt_q == BIT_LAST) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end
            end
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    state_d   = rx_s_q ? IDLE : DATA;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_DBG_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_DBG_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    par_err_d = rx_s_q ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d   = '0;
`ifdef UART_DBG_RX_PARITY_EN
                    push        = rx_s_q && !par_err_q;
`else
                    push        = rx_s_q;
`endif
                    frame_err_d = !push;
                    state_d     = rx_s_q ? IDLE : WAIT_IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    logic [7:0]    mem_q [MSG_QUEUE_SIZE];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_pop, do_push;

    // Pop is resolved first so a push into a full queue survives a same-cycle read
    always_comb begin
        do_pop     = rd && count_q != '0;
        do_push    = push && (count_q != DEPTH || do_pop);
        overflow_d = push && !do_push;
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign empty     = count_q == '0;
    assign msg       = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_dbg_rx.sv
// tb_uart_dbg_rx: directed frames against a queue-level model of the receiver,
// checked every cycle, plus literal expectations per scenario.
module tb_uart_dbg_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef UART_DBG_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Stop-bit centre after the start edge, plus two sync clocks and the queue write
    localparam int LAT = NBITS * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] msg;
    logic       empty, overflow, frame_err;

    uart_dbg_rx #(
        .SYS_CLK_FREQ  (16),
        .BAUD_RATE     (1),
        .MSG_QUEUE_SIZE(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd       (rd),
        .msg      (msg),
        .empty    (empty),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         ev_cyc[$];
    logic [7:0] ev_byte[$];
    bit         ev_good[$];
    int         ev_rd = 0;
    bit         exp_ovf = 0;
    bit         exp_ferr = 0;

    // Model: completed frames land at their due cycle; a same-cycle read pops first
    always @(posedge clk) begin
        cyc++;
        exp_ovf  = 0;
        exp_ferr = 0;
        if (reset) begin
            exp_q.delete();
            ev_rd = ev_cyc.size();
        end else begin
            if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
            while (ev_rd < ev_cyc.size() && ev_cyc[ev_rd] == cyc) begin
                if (!ev_good[ev_rd]) exp_ferr = 1;
                else if (exp_q.size() == DEPTH) exp_ovf = 1;
                else exp_q.push_back(ev_byte[ev_rd]);
                ev_rd++;
            end
        end
    end

    bit prev_empty = 1;
    int fall_cyc = -1;
    int ovf_cnt = 0;
    int ferr_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_empty", empty, 1);
            chk("rst_msg", msg, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_frame_err", frame_err, 0);
            prev_empty = 1;
        end else begin
            chk("empty", empty, exp_q.size() == 0);
            if (exp_q.size() != 0) chk("msg", msg, exp_q[0]);
            chk("overflow", overflow, exp_ovf);
            chk("frame_err", frame_err, exp_ferr);
            if (prev_empty && !empty) fall_cyc = cyc;
            prev_empty = empty;
            ovf_cnt += int'(overflow);
            ferr_cnt += int'(frame_err);
        end
    end

    task automatic bit_slot(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        ev_cyc.push_back(cyc + LAT);
        ev_byte.push_back(b);
        ev_good.push_back(stop_bit && !bad_par);
        bit_slot(1'b0);
        for (int i = 0; i < 8; i++) bit_slot(b[i]);
`ifdef UART_DBG_RX_PARITY_EN
        bit_slot((^b) ^ bad_par);
`endif
        bit_slot(stop_bit);
    endtask

    task automatic pop_check(input logic [7:0] want);
        chk("pop_nonempty", empty, 0);
        chk("pop_msg", msg, want);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    // Pulse rd exactly on the cycle the frame's byte is written
    task automatic send_with_rd(input logic [7:0] b);
        int t;
        t = cyc + LAT;
        fork
            send_frame(b, 1'b1, 1'b0);
            begin
                while (cyc < t - 1) begin
                    @(posedge clk);
                    #1;
                end
                rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, o0, f0, got;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_bits(4);

        // 1: single frame, latency and drain
        e0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("t1_latency", fall_cyc - e0, LAT);
        chk("t1_msg", msg, 8'hA5);
        pop_check(8'hA5);
        chk("t1_drained", empty, 1);

        // 2: fill past full, then push+rd while full, then rd while empty
        o0 = ovf_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        chk("t2_ovf_pulses", ovf_cnt - o0, 1);
        chk("t2_head", msg, 8'h00);
        send_with_rd(8'h09);
        chk("t2_ovf_after_swap", ovf_cnt - o0, 1);
        for (int i = 1; i < 8; i++) pop_check(8'(i));
        pop_check(8'h09);
        chk("t2_drained", empty, 1);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        chk("t2_rd_empty", empty, 1);
        send_with_rd(8'h42);
        pop_check(8'h42);
        chk("t2_empty_after_42", empty, 1);

        // 3: short start glitch
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(3);
        chk("t3_no_push", empty, 1);
        chk("t3_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        pop_check(8'h5A);

        // 4: bad stop bit, then recovery
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("t4_ferr_pulse", ferr_cnt - f0, 1);
        chk("t4_no_push", empty, 1);
        idle_bits(3);
        send_frame(8'h55, 1'b1, 1'b0);
        pop_check(8'h55);

        // 5: reset during data bit 4 of 0x81, released while rx is low
        f0 = ferr_cnt;
        bit_slot(1'b0);
        bit_slot(1'b1);
        for (int i = 1; i < 4; i++) bit_slot(1'b0);
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        chk("t5_rst_empty", empty, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bit_slot(1'b0);
        bit_slot(1'b0);
        bit_slot(1'b1);
        bit_slot(1'b1);
        idle_bits(2);
        chk("t5_no_push", empty, 1);
        chk("t5_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        pop_check(8'h81);

        // 6: loopback stream 0..255 with a consumer popping whenever data is present
        o0 = ovf_cnt;
        f0 = ferr_cnt;
        got = 0;
        fork
            for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1'b0);
            begin
                for (int c = 0; c < 256 * (NBITS + 1) * CPB + 400 && got < 256; c++) begin
                    rd = !empty;
                    if (!empty) begin
                        chk("t6_order", msg, got);
                        got++;
                    end
                    @(posedge clk);
                    #1;
                end
                rd = 1'b0;
            end
        join
        chk("t6_count", got, 256);
        chk("t6_no_ovf", ovf_cnt - o0, 0);
        chk("t6_no_ferr", ferr_cnt - f0, 0);

`ifdef UART_DBG_RX_PARITY_EN
        idle_bits(2);
        f0 = ferr_cnt;
        send_frame(8'h01, 1'b1, 1'b1);
        chk("t7_par_ferr", ferr_cnt - f0, 1);
        chk("t7_no_push", empty, 1);
        idle_bits(2);
        send_frame(8'h01, 1'b1, 1'b0);
        pop_check(8'h01);
`endif

        idle_bits(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
